// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS-subset control unit:
//   - opcode field values of the instruction set
//   - ALU operation, pc_source and alu_src_b encodings
//   - FSM state enum
//   - ctrl_t: the bundle of datapath strobes produced by the output decoder
// -----------------------------------------------------------------------------
package mips_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SUBI  = 6'b000011;
  localparam logic [5:0] OP_ANDI  = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b001001;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_SB    = 6'b010001;
  localparam logic [5:0] OP_BEQ   = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_MOVE  = 6'b100000;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111001;

  // ALU operations
  localparam logic [2:0] ALUOP_AND   = 3'b000;
  localparam logic [2:0] ALUOP_OR    = 3'b001;
  localparam logic [2:0] ALUOP_XOR   = 3'b010;
  localparam logic [2:0] ALUOP_NOR   = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;
  localparam logic [2:0] ALUOP_ADD   = 3'b101;
  localparam logic [2:0] ALUOP_SUB   = 3'b110;
  localparam logic [2:0] ALUOP_FUNCT = 3'b111;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // ALU B-operand select
  localparam logic [1:0] ALUSRCB_REG    = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM    = 2'd2;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_R_WB,
    ST_EXEC_I,
    ST_I_WB,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_BRANCH,
    ST_JUMP,
    ST_JR,
    ST_ILLEGAL
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       byte_op;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       link;
    logic       move;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mcu_output_decode.sv
// -----------------------------------------------------------------------------
// mcu_output_decode
// Purely combinational decoder from FSM state (plus the latched opcode and the
// memory handshake) to the datapath strobes.
// Ports:
//   state_i      current FSM state
//   opcode_i     opcode field from the instruction register
//   mem_ready_i  memory completes the current access this cycle
//   ctrl_o       strobe bundle (all zero outside the listed assertions)
// -----------------------------------------------------------------------------
module mcu_output_decode
  import mips_pkg::*;
#(
  parameter int OPCODE_W        = 6,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  state_e              state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ready_i,
  output ctrl_t               ctrl_o
);

  logic is_lb, is_sb, is_bne, is_jal, is_move;

  assign is_lb   = (opcode_i == OPCODE_W'(OP_LB));
  assign is_sb   = (opcode_i == OPCODE_W'(OP_SB));
  assign is_bne  = (opcode_i == OPCODE_W'(OP_BNE));
  assign is_jal  = (opcode_i == OPCODE_W'(OP_JAL));
  assign is_move = (opcode_i == OPCODE_W'(OP_MOVE));

  always_comb begin
    // NOTE: every field gets a value before the case so no path leaves a
    // strobe unassigned, which would infer a latch.
    ctrl_o = '0;
    unique case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        // IR and PC+4 are captured only on the cycle the fetch completes.
        if (mem_ready_i) begin
          ctrl_o.ir_write  = 1'b1;
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCSRC_ALU;
        end
      end
      ST_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        ctrl_o.alu_src_b = ALUSRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.move      = is_move;
        if (opcode_i == OPCODE_W'(OP_SUBI))      ctrl_o.alu_op = ALUOP_SUB;
        else if (opcode_i == OPCODE_W'(OP_ANDI)) ctrl_o.alu_op = ALUOP_AND;
        else if (opcode_i == OPCODE_W'(OP_ORI))  ctrl_o.alu_op = ALUOP_OR;
        else if (opcode_i == OPCODE_W'(OP_SLTI)) ctrl_o.alu_op = ALUOP_SLT;
        else                                     ctrl_o.alu_op = ALUOP_ADD;
      end
      ST_I_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.move       = is_move;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
        ctrl_o.byte_op  = is_lb;
      end
      ST_MEM_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.byte_op    = is_lb;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.byte_op    = is_sb;
        ctrl_o.instr_done = mem_ready_i;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALUSRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = is_bne;
        ctrl_o.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.reg_write  = is_jal;
        ctrl_o.link       = is_jal;
        ctrl_o.instr_done = 1'b1;
      end
      ST_JR: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_RS;
        ctrl_o.instr_done = 1'b1;
      end
      ST_ILLEGAL: begin
        // A trapped illegal opcode never retires; in NOP mode it does.
        ctrl_o.instr_done = !TRAP_ON_ILLEGAL;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Moore FSM sequencing each MIPS-subset instruction through fetch, decode,
// execute, memory and writeback on a shared-ALU/shared-memory datapath, with
// a variable-latency memory handshake, an illegal-opcode policy and a
// retired-instruction counter.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct       instruction register fields
//   mem_ready           memory completes the current access this cycle
//   zero                ALU zero flag (consumed by the datapath PC logic)
//   pc_write .. alu_op  datapath strobes, all 0 while reset is high
//   instr_done          pulse on the final cycle of each instruction
//   illegal_op          illegal-opcode flag (sticky when trapping)
//   retired_count       completed-instruction count, wraps
// -----------------------------------------------------------------------------
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int                 OPCODE_W        = 6,
  parameter int                 FUNCT_W         = 6,
  parameter logic [FUNCT_W-1:0] JR_FUNCT        = 6'b001000,
  parameter int                 ALUOP_W         = 3,
  parameter int                 CNT_W           = 32,
  parameter bit                 TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_source,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                byte_op,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                link,
  output logic                move,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  ctrl_t            ctrl_raw, ctrl;

  // The zero flag qualifies the PC load inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  mcu_output_decode #(
    .OPCODE_W        (OPCODE_W),
    .TRAP_ON_ILLEGAL (TRAP_ON_ILLEGAL)
  ) u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  // Gating with reset kills any strobe of an aborted instruction immediately
  // rather than one cycle later when the state register clears.
  assign ctrl = reset ? '0 : ctrl_raw;

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign pc_source     = ctrl.pc_source;
  assign ir_write      = ctrl.ir_write;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign byte_op       = ctrl.byte_op;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign link          = ctrl.link;
  assign move          = ctrl.move;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALUOP_W'(ctrl.alu_op);
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = illegal_q;
  assign retired_count = retired_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPCODE_W'(OP_RTYPE):
            state_d = (funct == JR_FUNCT) ? ST_JR : ST_EXEC_R;
          OPCODE_W'(OP_ADDI), OPCODE_W'(OP_SUBI), OPCODE_W'(OP_ANDI),
          OPCODE_W'(OP_ORI),  OPCODE_W'(OP_SLTI), OPCODE_W'(OP_MOVE):
            state_d = ST_EXEC_I;
          OPCODE_W'(OP_LW), OPCODE_W'(OP_LB),
          OPCODE_W'(OP_SW), OPCODE_W'(OP_SB):
            state_d = ST_MEM_ADDR;
          OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE):
            state_d = ST_BRANCH;
          OPCODE_W'(OP_J), OPCODE_W'(OP_JAL):
            state_d = ST_JUMP;
          default:
            state_d = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R:   state_d = ST_R_WB;
      ST_EXEC_I:   state_d = ST_I_WB;
      ST_MEM_ADDR: begin
        if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_LB))
          state_d = ST_MEM_READ;
        else
          state_d = ST_MEM_WRITE;
      end
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_ILLEGAL:   state_d = TRAP_ON_ILLEGAL ? ST_ILLEGAL : ST_FETCH;
      ST_R_WB, ST_I_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP, ST_JR:
        state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    retired_d = ctrl.instr_done ? retired_q + CNT_W'(1) : retired_q;
    // Trapping keeps the flag until reset; otherwise it marks only the
    // single cycle spent in ILLEGAL.
    if (TRAP_ON_ILLEGAL) illegal_d = illegal_q | (state_d == ST_ILLEGAL);
    else                 illegal_d = (state_d == ST_ILLEGAL);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed bench: two instances share one stimulus stream -- u_trap (defaults,
// trapping, 32-bit count) and u_nop (illegal-as-NOP, 4-bit count). Every cycle
// the full strobe vector is compared against a hand-written expectation.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       byte_op;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       link;
    logic       move;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
  } sig_t;

  logic       clk, reset, mem_ready, zero;
  logic [5:0] opcode, funct;

  logic       t_pcw, t_pcwc, t_bne, t_irw, t_iord, t_mr, t_mw, t_bo, t_m2r;
  logic       t_rd, t_rw, t_lk, t_mv, t_sa, t_done, t_ill;
  logic [1:0] t_pcs, t_sb;
  logic [2:0] t_op;
  logic [31:0] t_cnt;

  logic       n_pcw, n_pcwc, n_bne, n_irw, n_iord, n_mr, n_mw, n_bo, n_m2r;
  logic       n_rd, n_rw, n_lk, n_mv, n_sa, n_done, n_ill;
  logic [1:0] n_pcs, n_sb;
  logic [2:0] n_op;
  logic [3:0] n_cnt;

  int total = 0;
  int bad   = 0;

  multicycle_control_unit u_trap (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(t_pcw), .pc_write_cond(t_pcwc), .branch_ne(t_bne),
    .pc_source(t_pcs), .ir_write(t_irw), .i_or_d(t_iord),
    .mem_read(t_mr), .mem_write(t_mw), .byte_op(t_bo), .mem_to_reg(t_m2r),
    .reg_dst(t_rd), .reg_write(t_rw), .link(t_lk), .move(t_mv),
    .alu_src_a(t_sa), .alu_src_b(t_sb), .alu_op(t_op),
    .instr_done(t_done), .illegal_op(t_ill), .retired_count(t_cnt)
  );

  multicycle_control_unit #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(n_pcw), .pc_write_cond(n_pcwc), .branch_ne(n_bne),
    .pc_source(n_pcs), .ir_write(n_irw), .i_or_d(n_iord),
    .mem_read(n_mr), .mem_write(n_mw), .byte_op(n_bo), .mem_to_reg(n_m2r),
    .reg_dst(n_rd), .reg_write(n_rw), .link(n_lk), .move(n_mv),
    .alu_src_a(n_sa), .alu_src_b(n_sb), .alu_op(n_op),
    .instr_done(n_done), .illegal_op(n_ill), .retired_count(n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sig_t cur_trap();
    return {t_pcw, t_pcwc, t_bne, t_pcs, t_irw, t_iord, t_mr, t_mw, t_bo,
            t_m2r, t_rd, t_rw, t_lk, t_mv, t_sa, t_sb, t_op, t_done};
  endfunction

  function automatic sig_t cur_nop();
    return {n_pcw, n_pcwc, n_bne, n_pcs, n_irw, n_iord, n_mr, n_mw, n_bo,
            n_m2r, n_rd, n_rw, n_lk, n_mv, n_sa, n_sb, n_op, n_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, compare 1 ns later.
  task automatic cyc(input logic mr, input string tag, input sig_t exp);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = mr;
    #1;
    check(tag, 32'(cur_trap()), 32'(exp));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check({tag, "_trap_off"}, 32'(cur_trap()), 32'd0);
    check({tag, "_nop_off"},  32'(cur_nop()),  32'd0);
  endtask

  localparam logic [5:0] R = 6'b000000, ADD_F = 6'b100000, JR_F = 6'b001000;
  localparam logic [5:0] LW = 6'b001000, LB = 6'b001001, SW = 6'b010000;
  localparam logic [5:0] SB = 6'b010001, BEQ = 6'b100011, BNE = 6'b100111;
  localparam logic [5:0] MOVE = 6'b100000, SLTI = 6'b000111, JAL = 6'b111001;
  localparam logic [5:0] BAD = 6'b110110;

  sig_t s_zero, s_fetch, s_fetch_w, s_dec, s_exr, s_rwb, s_maddr;
  sig_t s_mrd_w, s_mrd_b, s_mwb_w, s_mwb_b, s_mwr_w0, s_mwr_w1, s_mwr_b1;
  sig_t s_br_ne, s_br_eq, s_jal, s_jr, s_exi_mv, s_iwb_mv, s_exi_slt, s_iwb;
  sig_t s_ill_nop;

  initial begin
    s_zero    = '0;
    s_fetch   = '{mem_read:1, alu_src_b:2'd1, alu_op:3'd5, ir_write:1,
                  pc_write:1, default:0};
    s_fetch_w = '{mem_read:1, alu_src_b:2'd1, alu_op:3'd5, default:0};
    s_dec     = '{alu_src_b:2'd3, alu_op:3'd5, default:0};
    s_exr     = '{alu_src_a:1, alu_op:3'd7, default:0};
    s_rwb     = '{reg_dst:1, reg_write:1, instr_done:1, default:0};
    s_maddr   = '{alu_src_a:1, alu_src_b:2'd2, alu_op:3'd5, default:0};
    s_mrd_w   = '{mem_read:1, i_or_d:1, default:0};
    s_mrd_b   = '{mem_read:1, i_or_d:1, byte_op:1, default:0};
    s_mwb_w   = '{mem_to_reg:1, reg_write:1, instr_done:1, default:0};
    s_mwb_b   = '{mem_to_reg:1, reg_write:1, byte_op:1, instr_done:1,
                  default:0};
    s_mwr_w0  = '{mem_write:1, i_or_d:1, default:0};
    s_mwr_w1  = '{mem_write:1, i_or_d:1, instr_done:1, default:0};
    s_mwr_b1  = '{mem_write:1, i_or_d:1, byte_op:1, instr_done:1, default:0};
    s_br_ne   = '{alu_src_a:1, alu_op:3'd6, pc_write_cond:1, pc_source:2'd1,
                  branch_ne:1, instr_done:1, default:0};
    s_br_eq   = '{alu_src_a:1, alu_op:3'd6, pc_write_cond:1, pc_source:2'd1,
                  instr_done:1, default:0};
    s_jal     = '{pc_write:1, pc_source:2'd2, reg_write:1, link:1,
                  instr_done:1, default:0};
    s_jr      = '{pc_write:1, pc_source:2'd3, instr_done:1, default:0};
    s_exi_mv  = '{alu_src_a:1, alu_src_b:2'd2, alu_op:3'd5, move:1, default:0};
    s_iwb_mv  = '{reg_write:1, move:1, instr_done:1, default:0};
    s_exi_slt = '{alu_src_a:1, alu_src_b:2'd2, alu_op:3'd4, default:0};
    s_iwb     = '{reg_write:1, instr_done:1, default:0};
    s_ill_nop = '{instr_done:1, default:0};

    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = R; funct = ADD_F;

    // Outputs are silent while reset is held.
    @(negedge clk); #1;
    check("reset_strobes", 32'(cur_trap()), 32'd0);

    // add: 4 cycles, register write only in the last one
    cyc(1, "add_fetch", s_fetch);
    check("reset_count",   t_cnt, 32'd0);
    check("reset_illegal", 32'(t_ill), 32'd0);
    cyc(1, "add_decode", s_dec);
    cyc(1, "add_exec",   s_exr);
    cyc(1, "add_wb",     s_rwb);

    // lw with two wait cycles in MEM_READ: 7 cycles
    opcode = LW;
    cyc(1, "lw_fetch", s_fetch);
    check("count_after_add", t_cnt, 32'd1);
    cyc(1, "lw_decode", s_dec);
    cyc(1, "lw_addr",   s_maddr);
    cyc(0, "lw_rd_w1",  s_mrd_w);
    cyc(0, "lw_rd_w2",  s_mrd_w);
    cyc(1, "lw_rd_ok",  s_mrd_w);
    cyc(1, "lw_wb",     s_mwb_w);

    // lb with one fetch wait
    opcode = LB;
    cyc(0, "lb_fetch_w", s_fetch_w);
    check("count_after_lw", t_cnt, 32'd2);
    cyc(1, "lb_fetch",  s_fetch);
    cyc(1, "lb_decode", s_dec);
    cyc(1, "lb_addr",   s_maddr);
    cyc(1, "lb_rd",     s_mrd_b);
    cyc(1, "lb_wb",     s_mwb_b);

    // sw with one write wait; instr_done only on the ready cycle
    opcode = SW;
    cyc(1, "sw_fetch",  s_fetch);
    cyc(1, "sw_decode", s_dec);
    cyc(1, "sw_addr",   s_maddr);
    cyc(0, "sw_wr_w",   s_mwr_w0);
    cyc(1, "sw_wr_ok",  s_mwr_w1);

    opcode = SB;
    cyc(1, "sb_fetch",  s_fetch);
    check("count_after_sw", t_cnt, 32'd4);
    cyc(1, "sb_decode", s_dec);
    cyc(1, "sb_addr",   s_maddr);
    cyc(1, "sb_wr",     s_mwr_b1);

    // branches: 3 cycles each
    opcode = BNE; zero = 1'b0;
    cyc(1, "bne_fetch",  s_fetch);
    cyc(1, "bne_decode", s_dec);
    cyc(1, "bne_branch", s_br_ne);
    opcode = BEQ; zero = 1'b1;
    cyc(1, "beq_fetch",  s_fetch);
    cyc(1, "beq_decode", s_dec);
    cyc(1, "beq_branch", s_br_eq);

    // jal then jr
    opcode = JAL;
    cyc(1, "jal_fetch",  s_fetch);
    check("count_after_br", t_cnt, 32'd7);
    cyc(1, "jal_decode", s_dec);
    cyc(1, "jal_jump",   s_jal);
    opcode = R; funct = JR_F;
    cyc(1, "jr_fetch",  s_fetch);
    cyc(1, "jr_decode", s_dec);
    cyc(1, "jr_jump",   s_jr);

    // move and slti through the immediate path
    opcode = MOVE;
    cyc(1, "mv_fetch",  s_fetch);
    cyc(1, "mv_decode", s_dec);
    cyc(1, "mv_exec",   s_exi_mv);
    cyc(1, "mv_wb",     s_iwb_mv);
    opcode = SLTI;
    cyc(1, "slti_fetch",  s_fetch);
    cyc(1, "slti_decode", s_dec);
    cyc(1, "slti_exec",   s_exi_slt);
    cyc(1, "slti_wb",     s_iwb);

    // illegal opcode: u_trap freezes, u_nop pulses and retires
    opcode = BAD;
    cyc(1, "ill_fetch",  s_fetch);
    check("count_before_ill", t_cnt, 32'd11);
    cyc(1, "ill_decode", s_dec);
    cyc(1, "ill_trap",   s_zero);
    check("ill_trap_flag", 32'(t_ill), 32'd1);
    check("ill_nop_sig",   32'(cur_nop()), 32'(s_ill_nop));
    check("ill_nop_flag",  32'(n_ill), 32'd1);
    cyc(1, "frozen_0", s_zero);
    check("ill_nop_fetch",    32'(cur_nop()), 32'(s_fetch));
    check("ill_nop_flag_clr", 32'(n_ill), 32'd0);
    check("ill_nop_count",    32'(n_cnt), 32'd12);
    for (int i = 1; i < 10; i++) begin
      cyc(1, $sformatf("frozen_%0d", i), s_zero);
      check($sformatf("frozen_flag_%0d", i), 32'(t_ill), 32'd1);
    end
    check("frozen_count", t_cnt, 32'd11);

    // reset clears the trap
    do_reset("rst1");
    opcode = SW;
    cyc(1, "rst1_fetch", s_fetch);
    check("rst1_illegal", 32'(t_ill), 32'd0);
    check("rst1_count",   t_cnt, 32'd0);
    check("rst1_nop_cnt", 32'(n_cnt), 32'd0);

    // reset in the middle of a pending store
    cyc(1, "sw2_decode", s_dec);
    cyc(1, "sw2_addr",   s_maddr);
    cyc(0, "sw2_wr_w",   s_mwr_w0);
    do_reset("rst_mw");

    // 16 retirements wrap the 4-bit count
    opcode = BEQ;
    for (int i = 0; i < 16; i++) begin
      zero = 1'(i);
      cyc(1, $sformatf("wrap_fetch_%0d", i), s_fetch);
      if (i == 0) check("rst_mw_count", t_cnt, 32'd0);
      cyc(1, $sformatf("wrap_decode_%0d", i), s_dec);
      cyc(1, $sformatf("wrap_branch_%0d", i), s_br_eq);
    end
    cyc(1, "wrap_end_fetch", s_fetch);
    check("wrap_trap_count", t_cnt, 32'd16);
    check("wrap_nop_count",  32'(n_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
